f8_3850_status_reg: RTL and testbench
=====================================

// Module: f8_3850_status_reg
// PURPOSE
//  W (status) register and flag consumer for the 3850 ALU: captures the ALU's c/z/ov/s
//  outputs under an update-mode command and feeds the stored carry back as the ALU c_in.
//  Evaluates BT/BF branch conditions one cycle after request, and holds the interrupt
//  control bit (ICB) with post-enable interrupt deferral.
//  Sits between the ALU and the sequencer/interrupt logic.
// PARAMETERS
//  DEFER_INSTR   2   instruction boundaries after an ICB 0->1 before irq_take may assert (1..3)
// PORTS
//  clk          in   1   single system clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  upd_valid    in   1   flag update strobe, one cycle per ALU op
//  upd_mode     in   3   0 NONE, 1 ARITH, 2 LOGIC, 3 SHIFT, 4 LOAD_J, 5 SET_ICB, 6 CLR_ICB, 7 rsvd
//  alu_c        in   1   ALU carry
//  alu_z        in   1   ALU zero
//  alu_ov       in   1   ALU overflow
//  alu_s        in   1   ALU sign flag (1 = result bit7 clear)
//  j_in         in   8   scratchpad J value for LR W,J (bits 4:0 used)
//  w_out        out  8   {3'b0, ICB, O, Z, C, S}, for LR J,W
//  c_fb         out  1   stored C, drives ALU c_in
//  br_req       in   1   branch test request, one-cycle strobe
//  br_false     in   1   0 = BT (t = mask[2:0]), 1 = BF (t = mask[3:0])
//  br_mask      in   4   test field t from opcode
//  br_valid     out  1   branch result valid, pulses the cycle after br_req
//  br_taken     out  1   branch decision, qualified by br_valid
//  instr_end    in   1   strobe at each instruction boundary
//  irq_req      in   1   level interrupt request
//  irq_take     out  1   combinational: irq_req & ICB & defer==0 & instr_end
// BEHAVIOUR
//  Reset: S,C,Z,O,ICB = 0; defer = 0; br_valid = 0; br_taken = 0; w_out = 0; c_fb = 0.
//  Update: all changes occur on the clk edge where upd_valid = 1. If upd_valid = 0, W holds.
//   ARITH  S,C,Z,O <= alu_s, alu_c, alu_z, alu_ov.
//   LOGIC  S,Z <= alu; C,O <= 0.
//   SHIFT  same as LOGIC.
//   LOAD_J {ICB,O,Z,C,S} <= j_in[4:0]; j_in[7:5] ignored.
//   SET/CLR_ICB  only ICB changes. NONE and rsvd change nothing.
//  c_fb = registered C. The new C is visible to the ALU the cycle after the update (1-cycle latency).
//  Branch: on a br_req edge, br_taken <= BT ? |(W[2:0] & t[2:0]) : ~|(W[3:0] & t).
//   br_valid <= br_req. The test uses W before any same-edge update, so a same-cycle
//   upd_valid does not affect it. BT t = 0 never branches; BF t = 0 always branches.
//  Interrupt deferral (see CONFIGURATION):
//   - Any ICB 0->1 transition (SET_ICB or LOAD_J) loads defer <= DEFER_INSTR.
//   - Otherwise, each instr_end with defer != 0 decrements defer.
//   - If an ICB 1->0 transition occurs, defer <= 0.
//   - If the ICB set and instr_end fall on the same edge, the load wins.
//  irq_take is combinational. The sequencer acks it, then issues CLR_ICB itself.
//  Reset mid-operation: async clear of all state. A pending br_valid is dropped, not replayed.
// CONFIGURATION
//  F8_ICB_DEFER_EN
//   Defined: the deferral counter above is implemented.
//   Undefined: defer is a constant 0, and irq_take = irq_req & ICB & instr_end.
//   DEFER_INSTR is ignored. The counter logic must be absent from synthesis.
// TESTING
//  1 Reset: hold rst_n=0 mid-clock -> w_out=8'h00, c_fb=0, br_valid=0 immediately (async).
//  2 Arith then logic: ARITH with c=1,z=0,ov=1,s=0 -> w_out=8'h0A, c_fb=1 next cycle;
//    then LOGIC with s=1,z=1 -> w_out=8'h05.
//  3 LOAD_J: j_in=8'hFF -> w_out=8'h1F. BT mask=4'b0000 -> taken=0. BF mask=4'b1000 -> taken=0.
//    BF mask=0 -> taken=1. Each br_valid arrives exactly 1 cycle after br_req.
//  4 Same-edge hazard: with W=0, br_req (BT t=2) and ARITH c=1 on the same edge
//    -> br_taken=0, c_fb=1.
//  5 Deferral (macro on, DEFER_INSTR=2): SET_ICB, irq_req=1
//    -> no irq_take on the 1st or 2nd instr_end, irq_take on the 3rd.
//    CLR_ICB then SET_ICB reloads 2.
//  6 Macro off: same stimulus as 5 -> irq_take on the 1st instr_end after SET_ICB.

Source files
------------

// File: rtl/f8_3850_status_reg.sv
// f8_3850_status_reg: W status register for the 3850 ALU.
// Captures the ALU flags by update mode, feeds carry back to the ALU, evaluates
// BT/BF branch tests one cycle after request, and holds the interrupt control
// bit. Optional interrupt deferral after ICB enable is built only when the
// macro F8_ICB_DEFER_EN is defined.
module f8_3850_status_reg #(
  parameter int DEFER_INSTR = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd_valid,
  input  logic [2:0] upd_mode,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_ov,
  input  logic       alu_s,
  input  logic [7:0] j_in,
  output logic [7:0] w_out,
  output logic       c_fb,
  input  logic       br_req,
  input  logic       br_false,
  input  logic [3:0] br_mask,
  output logic       br_valid,
  output logic       br_taken,
  input  logic       instr_end,
  input  logic       irq_req,
  output logic       irq_take
);

  typedef enum logic [2:0] {
    MODE_NONE    = 3'd0,
    MODE_ARITH   = 3'd1,
    MODE_LOGIC   = 3'd2,
    MODE_SHIFT   = 3'd3,
    MODE_LOAD_J  = 3'd4,
    MODE_SET_ICB = 3'd5,
    MODE_CLR_ICB = 3'd6,
    MODE_RSVD    = 3'd7
  } upd_mode_e;

  // Out-of-range deferral counts cannot be represented by the 2-bit counter.
  if (DEFER_INSTR < 1 || DEFER_INSTR > 3) begin : g_bad_defer
    $error("DEFER_INSTR must be in 1..3");
  end

  logic s_q, c_q, z_q, o_q, icb_q;
  logic s_n, c_n, z_n, o_n, icb_n;
  logic vld_p1, br_taken_p1;
  logic defer_zero;
  logic unused_j;

  // Only the low five bits of J map onto W.
  assign unused_j = ^j_in[7:5];

  // Next flag values selected by the update mode; W holds without a strobe.
  always_comb begin
    s_n   = s_q;
    c_n   = c_q;
    z_n   = z_q;
    o_n   = o_q;
    icb_n = icb_q;
    if (upd_valid) begin
      case (upd_mode_e'(upd_mode))
        MODE_ARITH: begin
          s_n = alu_s;
          c_n = alu_c;
          z_n = alu_z;
          o_n = alu_ov;
        end
        MODE_LOGIC, MODE_SHIFT: begin
          s_n = alu_s;
          z_n = alu_z;
          c_n = 1'b0;
          o_n = 1'b0;
        end
        MODE_LOAD_J:  {icb_n, o_n, z_n, c_n, s_n} = j_in[4:0];
        MODE_SET_ICB: icb_n = 1'b1;
        MODE_CLR_ICB: icb_n = 1'b0;
        default: ;
      endcase
    end
  end

  // W register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= 1'b0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
      o_q   <= 1'b0;
      icb_q <= 1'b0;
    end else begin
      s_q   <= s_n;
      c_q   <= c_n;
      z_q   <= z_n;
      o_q   <= o_n;
      icb_q <= icb_n;
    end
  end

  // Branch test uses W as it stood before this edge's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      br_taken_p1 <= 1'b0;
    end else begin
      vld_p1 <= br_req;
      if (br_req) begin
        if (br_false)
          br_taken_p1 <= ~|({o_q, z_q, c_q, s_q} & br_mask);
        else
          br_taken_p1 <= |({z_q, c_q, s_q} & br_mask[2:0]);
      end
    end
  end

`ifdef F8_ICB_DEFER_EN
  localparam logic [1:0] DEFER_LOAD = 2'(DEFER_INSTR);
  logic [1:0] defer_q;

  // Deferral counter: enable loads it, disable clears it, boundaries count down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      defer_q <= 2'd0;
    else if (!icb_q && icb_n)
      defer_q <= DEFER_LOAD;
    else if (icb_q && !icb_n)
      defer_q <= 2'd0;
    else if (instr_end && defer_q != 2'd0)
      defer_q <= defer_q - 2'd1;
  end

  assign defer_zero = (defer_q == 2'd0);
`else
  assign defer_zero = 1'b1;
`endif

  assign w_out    = {3'b000, icb_q, o_q, z_q, c_q, s_q};
  assign c_fb     = c_q;
  assign br_valid = vld_p1;
  assign br_taken = br_taken_p1;
  assign irq_take = irq_req & icb_q & defer_zero & instr_end;

endmodule

// File: tb/tb_f8_3850_status_reg.sv
// Directed bench for f8_3850_status_reg: a flag-level model of W, the branch
// test and the interrupt deferral is compared every cycle, plus literal checks.
module tb_f8_3850_status_reg;

  localparam int DEFER = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       upd_valid;
  logic [2:0] upd_mode;
  logic       alu_c, alu_z, alu_ov, alu_s;
  logic [7:0] j_in;
  logic [7:0] w_out;
  logic       c_fb;
  logic       br_req, br_false;
  logic [3:0] br_mask;
  logic       br_valid, br_taken;
  logic       instr_end, irq_req, irq_take;

  int vectors = 0;
  int errs    = 0;

  f8_3850_status_reg #(.DEFER_INSTR(DEFER)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_mode(upd_mode),
    .alu_c(alu_c), .alu_z(alu_z), .alu_ov(alu_ov), .alu_s(alu_s),
    .j_in(j_in), .w_out(w_out), .c_fb(c_fb),
    .br_req(br_req), .br_false(br_false), .br_mask(br_mask),
    .br_valid(br_valid), .br_taken(br_taken),
    .instr_end(instr_end), .irq_req(irq_req), .irq_take(irq_take)
  );

  always #5 clk = ~clk;

  // Model state: W as a 5-bit value {ICB,O,Z,C,S}, deferral count, branch result.
  logic [4:0] m_w;
  int         m_defer;
  logic       m_bv, m_bt;

  always @(posedge clk or negedge rst_n) begin
    logic [4:0] old_w, new_w;
    if (!rst_n) begin
      m_w = 5'd0; m_defer = 0; m_bv = 1'b0; m_bt = 1'b0;
    end else begin
      old_w = m_w;
      new_w = m_w;
      if (br_req)
        m_bt = br_false ? ((old_w[3:0] & br_mask) == 4'd0)
                        : ((old_w[2:0] & br_mask[2:0]) != 3'd0);
      m_bv = br_req;
      if (upd_valid) begin
        case (upd_mode)
          3'd1: new_w[3:0] = {alu_ov, alu_z, alu_c, alu_s};
          3'd2, 3'd3: new_w[3:0] = {1'b0, alu_z, 1'b0, alu_s};
          3'd4: new_w = j_in[4:0];
          3'd5: new_w[4] = 1'b1;
          3'd6: new_w[4] = 1'b0;
          default: ;
        endcase
      end
`ifdef F8_ICB_DEFER_EN
      if (!old_w[4] && new_w[4]) m_defer = DEFER;
      else if (old_w[4] && !new_w[4]) m_defer = 0;
      else if (instr_end && m_defer > 0) m_defer = m_defer - 1;
`endif
      m_w = new_w;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_w_out", w_out, {3'b000, m_w});
    chk("cmp_c_fb", {7'd0, c_fb}, {7'd0, m_w[1]});
    chk("cmp_br_valid", {7'd0, br_valid}, {7'd0, m_bv});
    if (m_bv) chk("cmp_br_taken", {7'd0, br_taken}, {7'd0, m_bt});
    chk("cmp_irq_take", {7'd0, irq_take},
        {7'd0, irq_req & m_w[4] & (m_defer == 0) & instr_end});
  end

  task automatic idle();
    upd_valid = 0; upd_mode = 3'd0; alu_c = 0; alu_z = 0; alu_ov = 0; alu_s = 0;
    j_in = 8'h00; br_req = 0; br_false = 0; br_mask = 4'h0; instr_end = 0;
  endtask

  // Apply the currently driven inputs on one edge, then clear the strobes.
  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic upd(input logic [2:0] mode, input logic c, input logic z,
                     input logic ov, input logic s, input logic [7:0] j);
    upd_valid = 1; upd_mode = mode; alu_c = c; alu_z = z; alu_ov = ov; alu_s = s; j_in = j;
  endtask

  task automatic branch(input logic bf, input logic [3:0] t, input logic exp_t,
                        input string name);
    br_req = 1; br_false = bf; br_mask = t;
    tick();
    @(negedge clk);
    chk({name, "_valid"}, {7'd0, br_valid}, 8'h01);
    chk({name, "_taken"}, {7'd0, br_taken}, {7'd0, exp_t});
    tick();
    @(negedge clk);
    chk({name, "_valid_drop"}, {7'd0, br_valid}, 8'h00);
  endtask

  // One instruction boundary; irq_take is checked while instr_end is high.
  task automatic boundary(input logic exp_take, input string name);
    instr_end = 1;
    @(negedge clk);
    chk(name, {7'd0, irq_take}, {7'd0, exp_take});
    tick();
  endtask

  initial begin
    idle();
    irq_req = 0;
    rst_n   = 0;
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_w_out", w_out, 8'h00);
    chk("rst_c_fb", {7'd0, c_fb}, 8'h00);
    chk("rst_br_valid", {7'd0, br_valid}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1;
    tick();

    // Arithmetic then logic update.
    upd(3'd1, 1, 0, 1, 0, 8'h00);
    tick();
    @(negedge clk);
    chk("arith_w", w_out, 8'h0A);
    chk("arith_c_fb", {7'd0, c_fb}, 8'h01);
    upd(3'd2, 1, 1, 1, 1, 8'h00);
    tick();
    @(negedge clk);
    chk("logic_w", w_out, 8'h05);
    chk("logic_c_fb", {7'd0, c_fb}, 8'h00);
    upd(3'd3, 0, 0, 0, 1, 8'h00);
    tick();
    @(negedge clk);
    chk("shift_w", w_out, 8'h01);
    upd(3'd7, 1, 1, 1, 1, 8'hFF);
    tick();
    @(negedge clk);
    chk("rsvd_hold", w_out, 8'h01);

    // LOAD_J and branch tests.
    upd(3'd4, 0, 0, 0, 0, 8'hFF);
    tick();
    @(negedge clk);
    chk("loadj_w", w_out, 8'h1F);
    branch(1'b0, 4'b0000, 1'b0, "bt_t0");
    branch(1'b1, 4'b1000, 1'b0, "bf_t8");
    branch(1'b1, 4'b0000, 1'b1, "bf_t0");
    branch(1'b0, 4'b0100, 1'b1, "bt_t4");

    // Same-edge hazard: branch sees W before the carry update.
    upd(3'd4, 0, 0, 0, 0, 8'hE0);
    tick();
    @(negedge clk);
    chk("loadj_zero", w_out, 8'h00);
    upd(3'd1, 1, 0, 0, 0, 8'h00);
    br_req = 1; br_false = 0; br_mask = 4'b0010;
    tick();
    @(negedge clk);
    chk("hazard_taken", {7'd0, br_taken}, 8'h00);
    chk("hazard_c_fb", {7'd0, c_fb}, 8'h01);
    branch(1'b0, 4'b0010, 1'b1, "bt_after_c");

    // Interrupt deferral after enable.
    irq_req = 1;
    upd(3'd5, 0, 0, 0, 0, 8'h00);
    tick();
    @(negedge clk);
    chk("set_icb_w", w_out, 8'h12);
`ifdef F8_ICB_DEFER_EN
    boundary(1'b0, "irq_ie1");
    boundary(1'b0, "irq_ie2");
    boundary(1'b1, "irq_ie3");
`else
    boundary(1'b1, "irq_ie1");
    boundary(1'b1, "irq_ie2");
`endif
    upd(3'd6, 0, 0, 0, 0, 8'h00);
    tick();
    boundary(1'b0, "irq_icb_off");
    upd(3'd5, 0, 0, 0, 0, 8'h00);
    tick();
`ifdef F8_ICB_DEFER_EN
    boundary(1'b0, "irq_reload1");
    boundary(1'b0, "irq_reload2");
`endif
    boundary(1'b1, "irq_reload_take");
    // Enable on the same edge as a boundary: the load wins.
    upd(3'd6, 0, 0, 0, 0, 8'h00);
    tick();
    upd(3'd4, 0, 0, 0, 0, 8'h10);
    instr_end = 1;
    tick();
`ifdef F8_ICB_DEFER_EN
    boundary(1'b0, "irq_sameedge1");
    boundary(1'b0, "irq_sameedge2");
`endif
    boundary(1'b1, "irq_sameedge_take");
    irq_req = 0;
    boundary(1'b0, "irq_no_req");

    // Asynchronous reset mid-cycle drops a pending branch result.
    upd(3'd1, 1, 1, 1, 1, 8'h00);
    tick();
    br_req = 1; br_false = 1; br_mask = 4'h0;
    @(posedge clk); #3;
    idle();
    rst_n = 0;
    #1;
    chk("async_w_out", w_out, 8'h00);
    chk("async_c_fb", {7'd0, c_fb}, 8'h00);
    chk("async_br_valid", {7'd0, br_valid}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
